// File: rtl/bch_page_enc_seq.sv
// Page-level sequencer for one bch_encode instance. It slices a byte stream into sectors,
// feeds each sector to the encoder, then buffers and drains the parity tagged by sector.
module bch_page_enc_seq #(
   parameter int unsigned BITS         = 8,
   parameter int unsigned SECTOR_BYTES = 512,
   parameter int unsigned ECC_BYTES    = 8,
   parameter int unsigned MAX_SECTORS  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_start,
   input  logic [2:0]      cmd_sectors,
   input  logic            cmd_abort,
   output logic            busy,
   output logic            done,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            enc_ready,
   output logic            enc_start,
   output logic            enc_ce,
   output logic [BITS-1:0] enc_data_in,
   input  logic [BITS-1:0] enc_data_out,
   input  logic            enc_ecc_bits,
   output logic [BITS-1:0] par_data,
   output logic [2:0]      par_sector,
   output logic            par_last,
   output logic            par_valid,
   input  logic            par_ready
);

   localparam int unsigned BYTE_W = $clog2(SECTOR_BYTES);
   localparam int unsigned PAR_W  = $clog2(ECC_BYTES);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(SECTOR_BYTES - 1);
   localparam logic [PAR_W-1:0]  LAST_PAR  = PAR_W'(ECC_BYTES - 1);
   localparam logic [2:0]        MAX_SECT  = 3'(MAX_SECTORS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ECC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   logic [BYTE_W-1:0] byte_cnt;
   logic [PAR_W-1:0]  par_cnt;
   logic [PAR_W-1:0]  rd_cnt;
   logic [2:0]        nsect;
   logic [2:0]        sector;
   logic [BITS-1:0]   par_buf [ECC_BYTES];
   logic [2:0]        clamped;

   // Sector count of a new command: 0 runs one sector, oversize requests saturate.
   always_comb begin
      clamped = cmd_sectors;
      if (cmd_sectors == 3'd0) begin
         clamped = 3'd1;
      end else if (cmd_sectors > MAX_SECT) begin
         clamped = MAX_SECT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         par_cnt  <= '0;
         rd_cnt   <= '0;
         nsect    <= '0;
         sector   <= '0;
         for (int i = 0; i < int'(ECC_BYTES); i++) begin
            par_buf[i] <= '0;
         end
      end else if (cmd_abort && (state != S_IDLE)) begin
         // Abort overrides every transition; the encoder resyncs on its next start.
         state    <= S_IDLE;
         byte_cnt <= '0;
         par_cnt  <= '0;
         rd_cnt   <= '0;
         sector   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_start && !cmd_abort) begin
                  nsect  <= clamped;
                  sector <= '0;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (enc_ready) begin
                  byte_cnt <= '0;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (in_valid) begin
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     par_cnt  <= '0;
                     state    <= S_ECC;
                  end else begin
                     byte_cnt <= byte_cnt + BYTE_W'(1);
                  end
               end
            end
            S_ECC: begin
               if (enc_ecc_bits) begin
                  par_buf[par_cnt] <= enc_data_out;
                  if (par_cnt == LAST_PAR) begin
                     par_cnt <= '0;
                     rd_cnt  <= '0;
                     state   <= S_DRAIN;
                  end else begin
                     par_cnt <= par_cnt + PAR_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (par_ready) begin
                  if (rd_cnt == LAST_PAR) begin
                     rd_cnt <= '0;
                     if (sector == (nsect - 3'd1)) begin
                        state <= S_DONE;
                     end else begin
                        sector <= sector + 3'd1;
                        state  <= S_WAIT;
                     end
                  end else begin
                     rd_cnt <= rd_cnt + PAR_W'(1);
                  end
               end
            end
            S_DONE: begin
               sector <= '0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake and encoder controls are decoded from the registered state and counters.
   assign busy        = (state == S_WAIT) || (state == S_DATA) ||
                        (state == S_ECC)  || (state == S_DRAIN);
   assign done        = (state == S_DONE);
   assign in_ready    = (state == S_DATA);
   assign enc_ce      = ((state == S_DATA) && in_valid) || (state == S_ECC);
   assign enc_start   = (state == S_DATA) && in_valid && (byte_cnt == '0);
   assign enc_data_in = in_data;
   assign par_valid   = (state == S_DRAIN);
   assign par_data    = par_buf[rd_cnt];
   assign par_sector  = sector;
   assign par_last    = (state == S_DRAIN) && (rd_cnt == LAST_PAR);

endmodule

// File: tb/tb_bch_page_enc_seq.sv
// Directed bench for bch_page_enc_seq with a simple linear encoder stand-in:
// parity byte k of a sector is the mod-256 sum of data bytes at positions i with i%8 == k.
module tb_bch_page_enc_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_start;
   logic [2:0] cmd_sectors;
   logic       cmd_abort;
   logic       busy;
   logic       done;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       enc_ready;
   logic       enc_start;
   logic       enc_ce;
   logic [7:0] enc_data_in;
   logic [7:0] enc_data_out;
   logic       enc_ecc_bits;
   logic [7:0] par_data;
   logic [2:0] par_sector;
   logic       par_last;
   logic       par_valid;
   logic       par_ready;

   int total  = 0;
   int bad    = 0;
   int starts = 0;

   logic [7:0] acc [8];
   logic [9:0] scnt;
   logic       in_ecc;
   logic [3:0] ecnt;

   always #5 clk = ~clk;

   bch_page_enc_seq dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_start    (cmd_start),
      .cmd_sectors  (cmd_sectors),
      .cmd_abort    (cmd_abort),
      .busy         (busy),
      .done         (done),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .enc_ready    (enc_ready),
      .enc_start    (enc_start),
      .enc_ce       (enc_ce),
      .enc_data_in  (enc_data_in),
      .enc_data_out (enc_data_out),
      .enc_ecc_bits (enc_ecc_bits),
      .par_data     (par_data),
      .par_sector   (par_sector),
      .par_last     (par_last),
      .par_valid    (par_valid),
      .par_ready    (par_ready)
   );

   // Encoder stand-in: 512 data beats, then two idle ECC beats, then 8 parity beats.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         scnt   <= '0;
         in_ecc <= 1'b0;
         ecnt   <= '0;
         for (int k = 0; k < 8; k++) acc[k] <= 8'h00;
      end else if (enc_ce) begin
         if (enc_start) begin
            for (int k = 1; k < 8; k++) acc[k] <= 8'h00;
            acc[0] <= enc_data_in;
            scnt   <= 10'd1;
            in_ecc <= 1'b0;
            ecnt   <= '0;
         end else if (in_ecc) begin
            if (ecnt == 4'd9) begin
               in_ecc <= 1'b0;
               ecnt   <= '0;
            end else begin
               ecnt <= ecnt + 4'd1;
            end
         end else begin
            acc[scnt[2:0]] <= acc[scnt[2:0]] + enc_data_in;
            if (scnt == 10'd511) begin
               scnt   <= '0;
               in_ecc <= 1'b1;
               ecnt   <= '0;
            end else begin
               scnt <= scnt + 10'd1;
            end
         end
      end
   end

   assign enc_ready    = !in_ecc;
   assign enc_ecc_bits = in_ecc && (ecnt >= 4'd2);
   assign enc_data_out = enc_ecc_bits ? acc[3'(ecnt - 4'd2)] : 8'hA5;

   always @(posedge clk) begin
      if (enc_start && enc_ce) starts <= starts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dbyte(input int pat, input int s, input int b);
      return (pat == 0) ? 8'h00 : 8'(b + 16 * s + 1);
   endfunction

   function automatic logic [7:0] exp_par(input int pat, input int s, input int k);
      logic [7:0] sum;
      sum = 8'h00;
      for (int j = 0; j < 64; j++) sum = sum + dbyte(pat, s, 8 * j + k);
      return sum;
   endfunction

   // One page: feeds data, checks every parity beat, optional drain stall, abort or mid-page start.
   task automatic run_page(input logic [2:0] cmd_n, input int exp_n, input int pat,
                           input bit toggle, input int stall_sec, input int abort_idx,
                           input logic [2:0] restart_n);
      int         fed, got_sec, ridx, cyc, s0;
      bit         fin, stalled;
      logic [7:0] hd;
      fed = 0; got_sec = 0; ridx = 0; cyc = 0; fin = 1'b0; stalled = 1'b0; s0 = starts;
      @(negedge clk);
      cmd_sectors = cmd_n;
      cmd_start   = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      while (!fin && cyc < 20000) begin
         cmd_start = 1'b0;
         if (done) begin
            chk("done_busy_low", 32'(busy), 32'd0);
            chk("sectors_seen", 32'(got_sec), 32'(exp_n));
            cmd_start   = 1'b1;
            cmd_sectors = 3'd2;
            @(negedge clk);
            cmd_start = 1'b0;
            chk("start_in_done_ignored", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
            fin = 1'b1;
         end else if (abort_idx >= 0 && fed == abort_idx && in_ready) begin
            in_valid  = 1'b0;
            cmd_abort = 1'b1;
            @(negedge clk);
            cmd_abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd0);
            repeat (8) begin
               chk("abort_no_done", 32'(done), 32'd0);
               chk("abort_no_par", 32'(par_valid), 32'd0);
               @(negedge clk);
            end
            chk("abort_sectors_seen", 32'(got_sec), 32'(exp_n));
            fin = 1'b1;
         end else begin
            if (par_valid && stall_sec == got_sec && !stalled) begin
               stalled   = 1'b1;
               par_ready = 1'b0;
               in_valid  = 1'b0;
               hd        = exp_par(pat, got_sec, ridx);
               repeat (20) begin
                  @(negedge clk);
                  cyc++;
                  chk("stall_data", 32'(par_data), 32'(hd));
                  chk("stall_sector", 32'(par_sector), 32'(got_sec));
                  chk("stall_last", 32'(par_last), 32'(ridx == 7));
                  chk("stall_valid", 32'(par_valid), 32'd1);
                  chk("stall_in_ready", 32'(in_ready), 32'd0);
               end
               par_ready = 1'b1;
            end
            if (par_valid && par_ready) begin
               chk("par_data", 32'(par_data), 32'(exp_par(pat, got_sec, ridx)));
               chk("par_sector", 32'(par_sector), 32'(got_sec));
               chk("par_last", 32'(par_last), 32'(ridx == 7));
               ridx++;
               if (ridx == 8) begin
                  ridx = 0;
                  got_sec++;
               end
            end
            if (restart_n != 3'd0 && cyc == 40) begin
               cmd_start   = 1'b1;
               cmd_sectors = restart_n;
            end
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data  = dbyte(pat, fed / 512, fed % 512);
            if (in_valid && in_ready) fed++;
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk("page_timeout", 32'd0, 32'd1);
      in_valid  = 1'b0;
      cmd_start = 1'b0;
      if (abort_idx < 0) chk("enc_start_count", 32'(starts - s0), 32'(exp_n));
   endtask

   initial begin
      int fed6;
      reset       = 1'b1;
      cmd_start   = 1'b0;
      cmd_abort   = 1'b0;
      cmd_sectors = 3'd0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      par_ready   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_par_valid", 32'(par_valid), 32'd0);
      chk("rst_par_last", 32'(par_last), 32'd0);
      chk("rst_enc_start", 32'(enc_start), 32'd0);
      chk("rst_enc_ce", 32'(enc_ce), 32'd0);
      chk("rst_par_sector", 32'(par_sector), 32'd0);
      reset = 1'b0;

      // single zero sector, continuous input
      run_page(3'd1, 1, 0, 1'b0, -1, -1, 3'd0);
      // four sectors, 50% input duty, drain stall in sector 2
      run_page(3'd4, 4, 1, 1'b1, 2, -1, 3'd0);
      // abort at byte 300 of sector 1, then a clean page
      run_page(3'd2, 1, 1, 1'b0, -1, 512 + 300, 3'd0);
      run_page(3'd2, 2, 1, 1'b0, -1, -1, 3'd0);

      // abort and start together in IDLE: command dropped
      @(negedge clk);
      cmd_start   = 1'b1;
      cmd_abort   = 1'b1;
      cmd_sectors = 3'd2;
      @(negedge clk);
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      chk("idle_abort_wins", 32'(busy), 32'd0);

      // start while busy ignored; sector count clamping
      run_page(3'd3, 3, 1, 1'b0, -1, -1, 3'd1);
      run_page(3'd0, 1, 1, 1'b0, -1, -1, 3'd0);
      run_page(3'd7, 4, 1, 1'b0, -1, -1, 3'd0);

      // reset asserted during the ECC phase
      @(negedge clk);
      cmd_sectors = 3'd1;
      cmd_start   = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      fed6 = 0;
      for (int i = 0; i < 3000 && fed6 < 512; i++) begin
         in_data  = dbyte(1, 0, fed6);
         in_valid = 1'b1;
         if (in_ready) fed6++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ecc_fed", 32'(fed6), 32'd512);
      chk("ecc_busy", 32'(busy), 32'd1);
      chk("ecc_in_ready", 32'(in_ready), 32'd0);
      chk("ecc_ce", 32'(enc_ce), 32'd1);
      chk("ecc_par_valid", 32'(par_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_enc_ce", 32'(enc_ce), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_par_valid", 32'(par_valid), 32'd0);
      chk("mid_rst_par_last", 32'(par_last), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_par_sector", 32'(par_sector), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      run_page(3'd1, 1, 1, 1'b0, -1, -1, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
